// File: rtl/pe_sync_ctrl.sv
// pe_sync_ctrl: masked barrier FSM, barrier timeout snapshot, stall counters.
// Define PE_SYNC_PER_PE_CNT_EN to build the per-PE stall counters.
module pe_sync_ctrl #(
    parameter int N_PE      = 8,
    parameter int CNT_L     = 32,
    parameter int TIMEOUT_L = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_PE-1:0]       pe_active_mask,
    input  logic [N_PE-1:0]       barrier_reached,
    output logic                  barrier_release,
    output logic [CNT_L-1:0]      barrier_cnt,
    input  logic [TIMEOUT_L-1:0]  timeout_limit,
    output logic                  timeout_err,
    output logic [N_PE-1:0]       timeout_pe,
    input  logic                  clr_err,
    input  logic                  monitor,
    input  logic                  clr_cnt,
    input  logic [N_PE-1:0]       rd_req,
    input  logic [N_PE-1:0]       rd_gnt,
    input  logic [N_PE-1:0]       wr_req,
    input  logic [N_PE-1:0]       wr_gnt,
    output logic [CNT_L-1:0]      rd_stall_total,
    output logic [CNT_L-1:0]      wr_stall_total,
    output logic [N_PE*CNT_L-1:0] rd_stall_pe,
    output logic [N_PE*CNT_L-1:0] wr_stall_pe
);

    localparam int PW = $clog2(N_PE + 1);

    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_REL  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    function automatic logic [PW-1:0] popcnt(input logic [N_PE-1:0] v);
        logic [PW-1:0] c;
        c = '0;
        for (int i = 0; i < N_PE; i++) begin
            c = c + PW'(v[i]);
        end
        return c;
    endfunction

    function automatic logic [CNT_L-1:0] sat_add(input logic [CNT_L-1:0] a,
                                                 input logic [PW-1:0]    b);
        logic [CNT_L:0] s;
        s = {1'b0, a} + (CNT_L + 1)'(b);
        return s[CNT_L] ? '1 : s[CNT_L-1:0];
    endfunction

    state_t               state_q;
    logic [N_PE-1:0]      mask_q;
    logic                 rel_q;
    logic [CNT_L-1:0]     bcnt_q;
    logic [TIMEOUT_L-1:0] tcnt_q;
    logic                 tdone_q;
    logic                 err_q;
    logic [N_PE-1:0]      tpe_q;
    logic [CNT_L-1:0]     rd_tot_q;
    logic [CNT_L-1:0]     wr_tot_q;

    logic                 all_in;
    logic                 in_wait;
    logic                 partial;
    logic                 fire;
    logic [PW-1:0]        rd_pc_d;
    logic [PW-1:0]        wr_pc_d;

    assign all_in  = (&(barrier_reached | ~pe_active_mask)) && (|pe_active_mask);
    assign in_wait = (state_q == S_WAIT);
    assign partial = in_wait && (|(barrier_reached & pe_active_mask)) && !all_in;
    assign fire    = partial && !tdone_q && (timeout_limit != '0)
                     && (tcnt_q == timeout_limit);
    assign rd_pc_d = popcnt(rd_req & ~rd_gnt);
    assign wr_pc_d = popcnt(wr_req & ~wr_gnt);

    // HOLD waits on the mask latched at release so held flags cannot re-fire
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_WAIT;
            mask_q  <= '0;
            rel_q   <= 1'b0;
        end else begin
            rel_q <= 1'b0;
            unique case (state_q)
                S_WAIT: begin
                    mask_q <= pe_active_mask;
                    if (all_in) begin
                        state_q <= S_REL;
                        rel_q   <= 1'b1;
                    end
                end
                S_REL:  state_q <= S_HOLD;
                S_HOLD: if (~|(barrier_reached & mask_q)) state_q <= S_WAIT;
                default: state_q <= S_WAIT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcnt_q <= '0;
        end else if (clr_cnt) begin
            bcnt_q <= '0;
        end else if (in_wait && all_in && (bcnt_q != '1)) begin
            bcnt_q <= bcnt_q + CNT_L'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt_q  <= '0;
            tdone_q <= 1'b0;
        end else if (partial) begin
            if (tcnt_q < timeout_limit) tcnt_q <= tcnt_q + TIMEOUT_L'(1);
            if (fire) tdone_q <= 1'b1;
        end else begin
            tcnt_q  <= '0;
            tdone_q <= 1'b0;
        end
    end

    // a fresh timeout beats a simultaneous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
            tpe_q <= '0;
        end else if (fire) begin
            err_q <= 1'b1;
            tpe_q <= pe_active_mask & ~barrier_reached;
        end else if (clr_err) begin
            err_q <= 1'b0;
            tpe_q <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_tot_q <= '0;
            wr_tot_q <= '0;
        end else if (clr_cnt) begin
            rd_tot_q <= '0;
            wr_tot_q <= '0;
        end else if (monitor) begin
            rd_tot_q <= sat_add(rd_tot_q, rd_pc_d);
            wr_tot_q <= sat_add(wr_tot_q, wr_pc_d);
        end
    end

`ifdef PE_SYNC_PER_PE_CNT_EN
    for (genvar g = 0; g < N_PE; g++) begin : g_pe
        logic [CNT_L-1:0] rd_q;
        logic [CNT_L-1:0] wr_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rd_q <= '0;
                wr_q <= '0;
            end else if (clr_cnt) begin
                rd_q <= '0;
                wr_q <= '0;
            end else if (monitor) begin
                rd_q <= sat_add(rd_q, PW'(rd_req[g] & ~rd_gnt[g]));
                wr_q <= sat_add(wr_q, PW'(wr_req[g] & ~wr_gnt[g]));
            end
        end

        assign rd_stall_pe[g*CNT_L +: CNT_L] = rd_q;
        assign wr_stall_pe[g*CNT_L +: CNT_L] = wr_q;
    end
`else
    assign rd_stall_pe = '0;
    assign wr_stall_pe = '0;
`endif

    assign barrier_release = rel_q;
    assign barrier_cnt     = bcnt_q;
    assign timeout_err     = err_q;
    assign timeout_pe      = tpe_q;
    assign rd_stall_total  = rd_tot_q;
    assign wr_stall_total  = wr_tot_q;

endmodule
